// File: rtl/upper_right_to_lower_left_scan_if.sv
// Request/result bundle for the anti-diagonal five-in-a-row scanner.
// The master side issues a scan request with the last placed stone and
// one player's board bitmap; the slave side reports progress and result.
interface upper_right_to_lower_left_scan_if;
    logic         start;  // scan request, sampled on the rising clock edge
    logic [3:0]   row;    // row of last placed stone, legal 0..14
    logic [3:0]   col;    // column of last placed stone, legal 0..14
    logic [224:0] ch;     // stone bitmap, bit index row*15+col
    logic         busy;   // scan in progress
    logic         done;   // one-cycle result-valid pulse
    logic         win;    // five or more in a row on the anti-diagonal

    modport master (
        output start,
        output row,
        output col,
        output ch,
        input  busy,
        input  done,
        input  win
    );

    modport slave (
        input  start,
        input  row,
        input  col,
        input  ch,
        output busy,
        output done,
        output win
    );
endinterface

// File: rtl/upper_right_to_lower_left_scan.sv
// Anti-diagonal (upper-right to lower-left) five-in-a-row detector for a
// fixed 15x15 board. On an accepted start the board bitmap is captured and
// the diagonal r+c = row+col is walked one cell per cycle from its upper-right
// end, counting consecutive stones. The walk stops as soon as five in a row
// are seen, or after the lower-left end cell has been examined.
module upper_right_to_lower_left_scan (
    input  logic                           clk,
    input  logic                           rst,
    upper_right_to_lower_left_scan_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_n;

    // Captured board and walk position (data path, not reset).
    logic [224:0] snap;
    logic [7:0]   idx;      // bit index of the cell examined this cycle
    logic [4:0]   remain;   // cells left on the diagonal, including this one

    // Control registers.
    logic [2:0]   run;      // consecutive stones seen so far, saturates at 5
    logic         win_q;
    logic         done_q;

    // Decoded request and per-cycle scan values.
    logic [4:0]   diag_sum;
    logic         coord_ok;
    logic         cell_bit;
    logic [2:0]   run_n;

    // FSM side outputs.
    logic         load;
    logic         step;
    logic         finish;
    logic         win_n;

    // Bit index of the upper-right end of diagonal s: (0,s) for s<=14,
    // otherwise (s-14,14).
    function automatic logic [7:0] start_index(input logic [4:0] s);
        logic [7:0] r;
        if (s <= 5'd14) begin
            return {3'b000, s};
        end
        r = {3'b000, s} - 8'd14;
        return r * 8'd15 + 8'd14;
    endfunction

    // Number of cells on diagonal s.
    function automatic logic [4:0] cell_count(input logic [4:0] s);
        return (s <= 5'd14) ? (s + 5'd1) : (5'd29 - s);
    endfunction

    // Run counter increment that never goes past five.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= 3'd5) ? 3'd5 : (v + 3'd1);
    endfunction

    assign diag_sum = {1'b0, bus.row} + {1'b0, bus.col};
    assign coord_ok = (bus.row <= 4'd14) && (bus.col <= 4'd14);
    assign cell_bit = snap[idx];
    assign run_n    = cell_bit ? sat_inc(run) : 3'd0;

    // State register; reset aborts any scan in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode plus load/step/finish strobes for the registers.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        win_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (coord_ok) begin
                        load    = 1'b1;
                        state_n = SCAN;
                    end else begin
                        // Off-board coordinates: report a loss immediately.
                        finish  = 1'b1;
                        win_n   = 1'b0;
                        state_n = DONE;
                    end
                end
            end
            SCAN: begin
                step = 1'b1;
                if (run_n == 3'd5) begin
                    finish  = 1'b1;
                    win_n   = 1'b1;
                    state_n = DONE;
                end else if (remain == 5'd1) begin
                    finish  = 1'b1;
                    win_n   = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Run counter, result and done pulse; the pulse follows the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            run    <= 3'd0;
            win_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            if (load) begin
                run <= 3'd0;
            end else if (step) begin
                run <= run_n;
            end
            if (finish) begin
                win_q <= win_n;
            end
        end
    end

    // Board capture and walk position: step is +14 bits (r+1, c-1).
    always_ff @(posedge clk) begin
        if (load) begin
            snap   <= bus.ch;
            idx    <= start_index(diag_sum);
            remain <= cell_count(diag_sum);
        end else if (step) begin
            idx    <= idx + 8'd14;
            remain <= remain - 5'd1;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.win  = win_q;

endmodule

// File: tb/tb_upper_right_to_lower_left_scan.sv
// Directed bench for the anti-diagonal five-in-a-row scanner.
module tb_upper_right_to_lower_left_scan;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    upper_right_to_lower_left_scan_if bus();

    upper_right_to_lower_left_scan dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // n stones starting at bit index first, spaced by stride bits.
    function automatic logic [224:0] line(input int first, input int stride, input int n);
        logic [224:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[first + i * stride] = 1'b1;
        end
        return v;
    endfunction

    // Issue one start and measure: lat = number of edges after the start
    // edge until done is seen, busy_cycles = cycles busy was high before that.
    // With disturb set, start is re-pulsed with garbage inputs mid-scan.
    task automatic run_scan(input logic [3:0] r, input logic [3:0] c,
                            input logic [224:0] b, input bit disturb,
                            output int lat, output int busy_cycles);
        @(negedge clk);
        bus.row   = r;
        bus.col   = c;
        bus.ch    = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        lat         = -1;
        busy_cycles = 0;
        if (bus.busy) busy_cycles++;
        for (int n = 1; n <= 40; n++) begin
            if (disturb && n <= 5) begin
                bus.start = 1'b1;
                bus.row   = 4'd15;
                bus.col   = 4'd3;
                bus.ch    = ~b;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
        bus.start = 1'b0;
    endtask

    int           lat;
    int           bc;
    int           done_seen;
    logic [224:0] v;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b1;   // must be ignored while in reset
        bus.row   = 4'd0;
        bus.col   = 4'd0;
        bus.ch    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_win",  bus.win,  0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", bus.busy, 0);

        // Corner (0,0): one-cell diagonal.
        v = '0; v[0] = 1'b1;
        run_scan(4'd0, 4'd0, v, 1'b0, lat, bc);
        check("corner_lat",  lat, 2);
        check("corner_busy", bc, 2);
        check("corner_win",  bus.win, 0);
        @(posedge clk); #1;
        check("corner_done_pulse", bus.done, 0);

        // Main anti-diagonal s=14, five stones at the lower-left end.
        run_scan(4'd12, 4'd2, line(154, 14, 5), 1'b0, lat, bc);
        check("main_lat",  lat, 16);
        check("main_win",  bus.win, 1);
        check("main_busy", bc, 16);

        // No stones on diagonal s=14; the r=c diagonal is full but irrelevant.
        run_scan(4'd0, 4'd14, line(0, 16, 5), 1'b0, lat, bc);
        check("neigh_lat", lat, 16);
        check("neigh_win", bus.win, 0);

        // Early exit after five stones at the upper-right end.
        run_scan(4'd2, 4'd12, line(14, 14, 5), 1'b0, lat, bc);
        check("early_lat",  lat, 6);
        check("early_win",  bus.win, 1);
        check("early_busy", bc, 6);
        @(posedge clk); #1;
        check("early_busy_after", bus.busy, 0);
        check("early_win_hold",   bus.win, 1);

        // Gap at (4,10): four, gap, one -> no win over the full diagonal.
        v = line(14, 14, 4); v[84] = 1'b1;
        run_scan(4'd0, 4'd14, v, 1'b0, lat, bc);
        check("broken_lat", lat, 16);
        check("broken_win", bus.win, 0);

        // Overline: six stones (2,12)..(7,7) -> win when the fifth is seen.
        run_scan(4'd5, 4'd9, line(42, 14, 6), 1'b0, lat, bc);
        check("over_lat", lat, 8);
        check("over_win", bus.win, 1);

        // Illegal coordinates: straight to the result, win cleared.
        run_scan(4'd15, 4'd3, '1, 1'b0, lat, bc);
        check("illegal_lat",  lat, 1);
        check("illegal_busy", bc, 1);
        check("illegal_win",  bus.win, 0);

        // Lower half, s=20: start (6,14), five stones from the start cell.
        run_scan(4'd8, 4'd12, line(104, 14, 5), 1'b0, lat, bc);
        check("low_early_lat", lat, 6);
        check("low_early_win", bus.win, 1);

        // s=20, nine cells, five stones at the lower-left end (10,10)..(14,6).
        run_scan(4'd10, 4'd10, line(160, 14, 5), 1'b0, lat, bc);
        check("low_end_lat", lat, 10);
        check("low_end_win", bus.win, 1);

        // s=28: single cell (14,14), stone present but only one.
        v = '0; v[224] = 1'b1;
        run_scan(4'd14, 4'd14, v, 1'b0, lat, bc);
        check("last_cell_lat", lat, 2);
        check("last_cell_win", bus.win, 0);

        // Start re-pulsed and board inverted while busy: result unchanged.
        run_scan(4'd12, 4'd2, line(154, 14, 5), 1'b1, lat, bc);
        check("robust_lat", lat, 16);
        check("robust_win", bus.win, 1);
        @(posedge clk); #1;
        check("robust_idle", bus.busy, 0);

        // Reset at scan cycle 3 aborts the scan without a done pulse.
        @(negedge clk);
        bus.row   = 4'd12;
        bus.col   = 4'd2;
        bus.ch    = line(154, 14, 5);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_seen = 0;
        for (int n = 1; n <= 2; n++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_win",  bus.win, 0);
        for (int n = 0; n < 20; n++) begin
            if (bus.done) done_seen++;
            @(posedge clk); #1;
        end
        check("abort_no_done", done_seen, 0);

        run_scan(4'd2, 4'd12, line(14, 14, 5), 1'b0, lat, bc);
        check("after_rst_lat", lat, 6);
        check("after_rst_win", bus.win, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
